data_mem_responder: RTL

//  Responder end of the MEM-stage data-memory interface. It serves load/store requests issued by the
//  EX/MEM pipeline buffer (MemRead, MemWrite, address, store data) with a programmable wait-state latency.
//  It drives mem_stall back to the pipeline to hold PC, IF/ID, ID/EX and EX/MEM while an access is pending.
//  It returns load data on data_out for the MEM/WB buffer.

---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: serves one load/store at a time with WAIT_CYCLES
// wait states, stalling the pipeline meanwhile. Optional MEM_ERR_EN adds the err pulse output.
module data_mem_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Memaddr_in,
    input  logic [DATA_W-1:0] data_in,
`ifdef MEM_ERR_EN
    output logic              err,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              mem_stall
);

    localparam int unsigned CntW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem_q [Depth];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_stall  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MemRead || MemWrite) begin
                    mem_stall = 1'b1;
                    addr_d    = Memaddr_in;
                    wdata_d   = data_in;
                    rd_d      = MemRead;
                    wr_d      = MemWrite;
                    cnt_d     = CntW'(WAIT_CYCLES);
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                mem_stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StDone;
`ifdef MEM_ERR_EN
                    // Simultaneous read+write is a protocol error: abort without touching memory
                    if (rd_q && wr_q) begin
                        err_d = 1'b1;
                    end else if (wr_q) begin
`else
                    if (wr_q) begin
`endif
                        mem_we = 1'b1;
                    end else if (rd_q) begin
                        dout_d     = mem_q[addr_q];
                        rd_valid_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Array is not reset; a reset on the access edge suppresses the write
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign data_out = dout_q;
    assign rd_valid = rd_valid_q;
`ifdef MEM_ERR_EN
    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
